spi_master: RTL

Byte-oriented SPI master with a data/command (DC) sideband line. It serialises one command byte with `spi_dc_o` low, then N data bytes with `spi_dc_o` high, MSB first. It captures MISO into received bytes during the data phase. It is the host-side counterpart of `spi_slave`/`control`, and is used in the system-level bench and in host-emulation builds to write configuration and read back measurement registers.

---
 rtl/spi_master.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/spi_master.sv
// Byte-oriented SPI master (SCLK idles low, sample on rise): one command byte
// with DC low, then data_len bytes with DC high, MSB first; MISO captured per data byte.
module spi_master #(
    parameter int CLK_DIV = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       xfer_start_i,
    input  logic [7:0] cmd_i,
    input  logic [7:0] data_len_i,
    input  logic       tx_byte_vld_i,
    input  logic [7:0] tx_byte_data_i,
    output logic       tx_byte_rdy_o,
    output logic       rx_byte_vld_o,
    output logic [7:0] rx_byte_data_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       spi_sclk_o,
    output logic       spi_mosi_o,
    output logic       spi_cs_n_o,
    output logic       spi_dc_o,
    input  logic       spi_miso_i
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_CMD, S_GAP, S_DATA, S_HOLD
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       byte_cnt;
    logic [7:0]       tx_shift;
    logic [6:0]       rx_shift;
    logic             div_zero;
    logic             div_one;

    assign div_zero = (div_cnt == '0);
    assign div_one  = (div_cnt == DIV_ONE);

    // NOTE: every register here is written with <= so all branches see pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= S_IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            byte_cnt       <= '0;
            tx_shift       <= '0;
            rx_shift       <= '0;
            tx_byte_rdy_o  <= 1'b0;
            rx_byte_vld_o  <= 1'b0;
            rx_byte_data_o <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            spi_sclk_o     <= 1'b0;
            spi_mosi_o     <= 1'b0;
            spi_cs_n_o     <= 1'b1;
            spi_dc_o       <= 1'b0;
        end else begin
            done_o        <= 1'b0;
            rx_byte_vld_o <= 1'b0;
            case (state)
                S_IDLE: if (xfer_start_i) begin
                    state      <= S_SETUP;
                    busy_o     <= 1'b1;
                    spi_cs_n_o <= 1'b0;
                    spi_dc_o   <= 1'b0;
                    tx_shift   <= cmd_i;
                    byte_cnt   <= data_len_i;
                    div_cnt    <= DIV_LOAD;
                end
                S_SETUP: if (div_zero) begin
                    state      <= S_CMD;
                    spi_mosi_o <= tx_shift[7];
                    bit_cnt    <= 3'd7;
                    div_cnt    <= DIV_LOAD;
                end else begin
                    div_cnt <= div_cnt - DIV_ONE;
                end
                S_CMD: if (!div_zero) begin
                    div_cnt <= div_cnt - DIV_ONE;
                end else begin
                    div_cnt    <= DIV_LOAD;
                    spi_sclk_o <= ~spi_sclk_o;
                    if (spi_sclk_o) begin
                        if (bit_cnt == 3'd0) begin
                            spi_mosi_o <= 1'b0;
                            if (byte_cnt == 8'd0) begin
                                state <= S_HOLD;
                            end else begin
                                // The request cycle for the first byte is the last gap cycle.
                                spi_dc_o      <= 1'b1;
                                state         <= (CLK_DIV == 1) ? S_DATA : S_GAP;
                                tx_byte_rdy_o <= (CLK_DIV == 1);
                            end
                        end else begin
                            bit_cnt    <= bit_cnt - 3'd1;
                            tx_shift   <= {tx_shift[6:0], 1'b0};
                            spi_mosi_o <= tx_shift[6];
                        end
                    end
                end
                S_GAP: begin
                    div_cnt <= div_cnt - DIV_ONE;
                    if (div_one) begin
                        state         <= S_DATA;
                        tx_byte_rdy_o <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_byte_rdy_o && tx_byte_vld_i) begin
                        tx_byte_rdy_o <= 1'b0;
                        tx_shift      <= tx_byte_data_i;
                        spi_mosi_o    <= tx_byte_data_i[7];
                        spi_sclk_o    <= 1'b0;
                        bit_cnt       <= 3'd7;
                        byte_cnt      <= byte_cnt - 8'd1;
                        div_cnt       <= DIV_LOAD;
                    end else if (tx_byte_rdy_o && !spi_sclk_o) begin
                        // Stalled: SCLK low, MOSI/DC held until the byte arrives.
                    end else if (!div_zero) begin
                        div_cnt <= div_cnt - DIV_ONE;
                        if (div_one && spi_sclk_o && bit_cnt == 3'd0 && byte_cnt != 8'd0)
                            tx_byte_rdy_o <= 1'b1;
                    end else if (!spi_sclk_o) begin
                        spi_sclk_o <= 1'b1;
                        div_cnt    <= DIV_LOAD;
                        rx_shift   <= {rx_shift[5:0], spi_miso_i};
                        if (bit_cnt == 3'd0) begin
                            rx_byte_data_o <= {rx_shift, spi_miso_i};
                            rx_byte_vld_o  <= 1'b1;
                            if (CLK_DIV == 1 && byte_cnt != 8'd0)
                                tx_byte_rdy_o <= 1'b1;
                        end
                    end else begin
                        spi_sclk_o <= 1'b0;
                        div_cnt    <= DIV_LOAD;
                        if (bit_cnt != 3'd0) begin
                            bit_cnt    <= bit_cnt - 3'd1;
                            tx_shift   <= {tx_shift[6:0], 1'b0};
                            spi_mosi_o <= tx_shift[6];
                        end else if (byte_cnt == 8'd0) begin
                            state      <= S_HOLD;
                            spi_mosi_o <= 1'b0;
                        end
                    end
                end
                S_HOLD: if (done_o) begin
                    // One extra cycle so a start coinciding with done is not accepted.
                    state <= S_IDLE;
                end else if (div_zero) begin
                    spi_cs_n_o <= 1'b1;
                    spi_dc_o   <= 1'b0;
                    busy_o     <= 1'b0;
                    done_o     <= 1'b1;
                end else begin
                    div_cnt <= div_cnt - DIV_ONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
